// File: rtl/traffic_pkg.sv
// Shared constants for the traffic countdown display: segment codes, digit codes,
// controller phase encodings and small decode helpers.
package traffic_pkg;

  localparam int unsigned SCAN_W = 20;

  // Segment codes {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  localparam logic [3:0] DIG_DASH  = 4'hA;

  typedef enum logic [2:0] {
    MGCR = 3'd0,
    MYCR = 3'd1,
    MRCG = 3'd2,
    MRCY = 3'd3,
    NOC  = 3'd4
  } phase_t;

  // Digit code (0..9 or dash) to segment pattern
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  // Snapshot value plus its BCD to a {tens,units} digit pair; 0 and >=99 show dashes
  function automatic logic [7:0] digit_pair(input logic [7:0] v, input logic [11:0] bcd);
    if (v == 8'd0 || v >= 8'd99 || bcd[11:8] != 4'd0) return {DIG_DASH, DIG_DASH};
    return bcd[7:0];
  endfunction

endpackage

// File: rtl/traffic_display_if.sv
// Countdown/lamp inputs from the controller and display pins towards the board.
interface traffic_display_if;
  logic [7:0] count;
  logic [7:0] count_c;
  logic       mg;
  logic       cg;
  logic       my;
  logic       cy;
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (output count, count_c, mg, cg, my, cy, input seg, an, busy);
  modport slave  (input count, count_c, mg, cg, my, cy, output seg, an, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift with add-3 correction).
// start loads bin; eight shift cycles later bcd is valid and done pulses for one cycle.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        set,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  sr;
  logic [11:0] acc;
  logic [2:0]  cnt;
  logic        run;
  logic [11:0] adj_c;
  logic [11:0] shl_c;

  // Add-3 on every nibble >= 5, then shift in the next binary bit
  always_comb begin
    adj_c = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shl_c = 12'({adj_c, sr[7]});
  end

  // Load, iterate eight times, publish result with a done pulse
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      sr   <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= bin;
        acc <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        acc <= shl_c;
        sr  <= {sr[6:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          run  <= 1'b0;
          done <= 1'b1;
          bcd  <= shl_c;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_display.sv
// Four-digit multiplexed countdown display for the traffic controller.
// Optional feature macro: YELLOW_BLINK_EN (blink a road's digit pair while its yellow is on).
module traffic_display
  import traffic_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000
`ifdef YELLOW_BLINK_EN
  , parameter int unsigned BLINK_DIV = 12
`endif
) (
  input  logic               clk,
  input  logic               set,
  traffic_display_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MAIN, ST_CTRY} state_t;

  state_t            st;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [7:0]        snap_main;
  logic [7:0]        snap_ctry;
  logic [7:0]        pend_main;
  logic [3:0]        dig_mt, dig_mu, dig_ct, dig_cu;
  logic [11:0]       bcd;
  logic              done;
  logic              tick_c;
  logic              frame_start_c;
  logic              start_c;
  logic [7:0]        bin_c;
  logic [3:0]        dsel_c;
  logic [7:0]        seg_c;
  logic              blank_main_c;
  logic              blank_ctry_c;

  assign tick_c        = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_start_c = tick_c && (idx == 2'd0);
  // Main value converts straight from the live input on the snapshot edge, country follows
  assign start_c       = frame_start_c || (st == ST_MAIN && done);
  assign bin_c         = frame_start_c ? bus.count : snap_ctry;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .set   (set),
    .start (start_c),
    .bin   (bin_c),
    .bcd   (bcd),
    .done  (done)
  );

`ifdef YELLOW_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  // Frame-rate blink phase; parked at "shown" while neither yellow is on
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!bus.my && !bus.cy) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_start_c) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign blank_main_c = bus.my && blink_off;
  assign blank_ctry_c = bus.cy && blink_off;
`else
  logic unused_yellow;
  assign unused_yellow = bus.my ^ bus.cy;
  assign blank_main_c  = 1'b0;
  assign blank_ctry_c  = 1'b0;
`endif

  // Segment pattern for the digit being enabled next, with live dp and blanking
  always_comb begin
    case (idx)
      2'd3:    dsel_c = dig_mt;
      2'd2:    dsel_c = dig_mu;
      2'd1:    dsel_c = dig_ct;
      default: dsel_c = dig_cu;
    endcase
    seg_c = seg_of(dsel_c);
    if ((idx == 2'd2 && bus.mg) || (idx == 2'd0 && bus.cg)) seg_c[7] = 1'b0;
    if (idx[1] ? blank_main_c : blank_ctry_c) seg_c = SEG_OFF;
  end

  // Scan divider, digit drive, snapshot and conversion sequencing
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      st        <= ST_IDLE;
      scan_cnt  <= '0;
      idx       <= 2'd3;
      snap_main <= '0;
      snap_ctry <= '0;
      pend_main <= {DIG_DASH, DIG_DASH};
      dig_mt    <= DIG_DASH;
      dig_mu    <= DIG_DASH;
      dig_ct    <= DIG_DASH;
      dig_cu    <= DIG_DASH;
      bus.an    <= DIGIT_OFF;
      bus.seg   <= SEG_OFF;
      bus.busy  <= 1'b0;
    end else begin
      scan_cnt <= tick_c ? '0 : scan_cnt + SCAN_W'(1);
      if (tick_c) begin
        idx     <= idx - 2'd1;
        bus.an  <= ~(4'b0001 << idx);
        bus.seg <= seg_c;
      end
      case (st)
        ST_IDLE: begin
          if (frame_start_c) begin
            snap_main <= bus.count;
            snap_ctry <= bus.count_c;
            bus.busy  <= 1'b1;
            st        <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (done) begin
            pend_main <= digit_pair(snap_main, bcd);
            st        <= ST_CTRY;
          end
        end
        ST_CTRY: begin
          if (done) begin
            {dig_mt, dig_mu} <= pend_main;
            {dig_ct, dig_cu} <= digit_pair(snap_ctry, bcd);
            bus.busy         <= 1'b0;
            st               <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_display.sv
// Directed bench for traffic_display with SCAN_DIV=32 (and BLINK_DIV=2 when blinking is built in).
module tb_traffic_display;
  import traffic_pkg::*;

  logic clk;
  logic set;
  int   checks;
  int   errors;
  int   n;

  traffic_display_if bus();

  traffic_display #(
    .SCAN_DIV (32)
`ifdef YELLOW_BLINK_EN
    , .BLINK_DIV (2)
`endif
  ) dut (
    .clk (clk),
    .set (set),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge at which digit d has just become enabled
  task automatic wait_digit(input int d);
    logic [3:0] tgt;
    logic [3:0] prev;
    bit         hit;
    tgt  = ~(4'(4'b0001 << d));
    prev = bus.an;
    hit  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.an == tgt && prev != tgt) begin
        hit = 1'b1;
        break;
      end
      prev = bus.an;
    end
    check($sformatf("digit%0d_reached", d), 32'(hit), 32'd1);
  endtask

  task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
    wait_digit(d);
    check(tag, 32'(bus.seg), 32'(exp));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    set           = 1'b1;
    bus.count     = 8'd25;
    bus.count_c   = 8'd30;
    bus.mg        = 1'b1;
    bus.cg        = 1'b0;
    bus.my        = 1'b0;
    bus.cy        = 1'b0;

    // 1: reset values, first enabled digit is main tens showing a dash
    repeat (3) @(negedge clk);
    set = 1'b0;
    @(negedge clk);
    check("rst_an", 32'(bus.an), 32'h0000000F);
    check("rst_seg", 32'(bus.seg), 32'h000000FF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check_digit(3, SEG_DASH, "rst_mt_dash");
    check("rst_an_first", 32'(bus.an), 32'h00000007);
    check_digit(2, 8'h3F, "rst_mu_dash_dp");

    // 2: 25 / 30 with main green; busy lasts 18 cycles from the snapshot
    wait_digit(0);
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'd18);
    check_digit(3, SEG_2, "v25_mt");
    check_digit(2, 8'h12, "v25_mu_dp");
    check_digit(1, SEG_3, "v30_ct");
    check_digit(0, SEG_0, "v30_cu");

    // 3: NOC (0 / 99) shows dashes everywhere, then 7 shows as 07
    bus.count   = 8'd0;
    bus.count_c = 8'd99;
    bus.mg      = 1'b0;
    wait_digit(0);
    check_digit(3, SEG_DASH, "noc_mt");
    check_digit(2, SEG_DASH, "noc_mu");
    check_digit(1, SEG_DASH, "noc_ct");
    check_digit(0, SEG_DASH, "noc_cu");
    bus.count = 8'd7;
    wait_digit(0);
    check_digit(3, SEG_0, "v07_mt");
    check_digit(2, SEG_7, "v07_mu");
    check_digit(1, SEG_DASH, "v99_ct");

    // Boundaries: 98 is the largest shown value, 1 the smallest
    bus.count   = 8'd98;
    bus.count_c = 8'd1;
    wait_digit(0);
    check_digit(3, SEG_9, "v98_mt");
    check_digit(2, SEG_8, "v98_mu");
    check_digit(1, SEG_0, "v01_ct");
    check_digit(0, SEG_1, "v01_cu");

    // 4: change 21 -> 20 during conversion; the snapshot (21) is displayed
    bus.count = 8'd21;
    wait_digit(0);
    repeat (3) @(negedge clk);
    check("busy_mid", 32'(bus.busy), 32'd1);
    bus.count = 8'd20;
    check_digit(3, SEG_2, "snap21_mt");
    check_digit(2, SEG_1, "snap21_mu");
    wait_digit(0);
    check_digit(3, SEG_2, "v20_mt");
    check_digit(2, SEG_0, "v20_mu");

    // 5: set asserted in cycle 5 of a conversion, then recovery
    wait_digit(0);
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    set = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_an", 32'(bus.an), 32'h0000000F);
    check("abort_seg", 32'(bus.seg), 32'h000000FF);
    @(negedge clk);
    set = 1'b0;
    @(negedge clk);
    check("post_an", 32'(bus.an), 32'h0000000F);
    check_digit(3, SEG_DASH, "post_mt_dash");
    wait_digit(0);
    check("post_busy", 32'(bus.busy), 32'd1);
    check_digit(3, SEG_2, "rec_mt");
    check_digit(2, SEG_0, "rec_mu");

`ifdef YELLOW_BLINK_EN
    // 6: main yellow blinks the main pair 2 frames on / 2 frames off
    bus.count   = 8'd5;
    bus.count_c = 8'd30;
    wait_digit(0);
    bus.my = 1'b1;
    for (int f = 0; f < 6; f++) begin
      check_digit(3, (f < 2 || f >= 4) ? SEG_0 : SEG_OFF, $sformatf("blink_mt_f%0d", f));
      check_digit(2, (f < 2 || f >= 4) ? SEG_5 : SEG_OFF, $sformatf("blink_mu_f%0d", f));
      check_digit(1, SEG_3, $sformatf("blink_ct_f%0d", f));
      wait_digit(0);
    end
    bus.my = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
